// File: rtl/hwpe_stream_fifo_scm_ctrl_pkg.sv
// Shared types and helpers for the SCM FIFO controller.
// The flags type is used only when HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN is defined.
package hwpe_stream_fifo_scm_ctrl_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } fifo_scm_flags_t;

  function automatic int unsigned fifo_scm_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/hwpe_stream_fifo_scm_ctrl.sv
// Pointer/occupancy controller in front of a latch-based SCM FIFO storage array.
// Optional almost_full/occupancy outputs: define HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN.
module hwpe_stream_fifo_scm_ctrl
  import hwpe_stream_fifo_scm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ALMOST_FULL_TH = fifo_scm_depth(ADDR_WIDTH) - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_pop_valid,
  input  logic                  i_pop_ready,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_scm_re,
  output logic [ADDR_WIDTH-1:0] o_scm_raddr,
  input  logic [DATA_WIDTH-1:0] i_scm_rdata,
  output logic                  o_scm_we,
  output logic [ADDR_WIDTH-1:0] o_scm_waddr,
  output logic [DATA_WIDTH-1:0] o_scm_wdata,
  output logic                  o_empty,
  output logic                  o_full
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN
  ,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_occupancy
`endif
);

  localparam int unsigned         Depth    = fifo_scm_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);

  logic                  w_in_rst;
  logic                  w_push_ready;
  logic                  w_push_fire;
  logic                  w_pop_valid;
  logic                  w_pop_fire;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
  logic [ADDR_WIDTH:0]   r_alloc_cnt;
  logic [ADDR_WIDTH:0]   w_alloc_cnt_next;
  logic                  r_wr_pend;

  assign w_in_rst     = i_rst | i_clear;
  assign w_push_ready = ~w_in_rst & (r_alloc_cnt != DepthCnt);
  assign w_push_fire  = i_push_valid & w_push_ready;

  // Last cycle's write sits in an open latch this cycle, so every allocated entry
  // is already readable; the current cycle's write is not yet counted.
  assign w_pop_valid  = ~w_in_rst & (r_alloc_cnt != '0);
  assign w_pop_fire   = w_pop_valid & i_pop_ready;

  assign w_rd_ptr_next = r_rd_ptr + ADDR_WIDTH'(w_pop_fire);

  always_comb begin
    w_alloc_cnt_next = r_alloc_cnt;
    case ({w_push_fire, w_pop_fire})
      2'b10:   w_alloc_cnt_next = r_alloc_cnt + 1'b1;
      2'b01:   w_alloc_cnt_next = r_alloc_cnt - 1'b1;
      default: w_alloc_cnt_next = r_alloc_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_in_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_alloc_cnt <= '0;
      r_wr_pend   <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(w_push_fire);
      r_rd_ptr    <= w_rd_ptr_next;
      r_alloc_cnt <= w_alloc_cnt_next;
      r_wr_pend   <= w_push_fire;
    end
  end

  assign o_push_ready = w_push_ready;
  assign o_pop_valid  = w_pop_valid;
  assign o_pop_data   = i_scm_rdata;

  // Read address leads rd_ptr by one pop so the SCM read register tracks rd_ptr;
  // forcing 0 in reset initialises that otherwise unreset register.
  assign o_scm_re    = 1'b1;
  assign o_scm_raddr = w_in_rst ? '0 : w_rd_ptr_next;

  assign o_scm_we    = w_push_fire;
  assign o_scm_waddr = r_wr_ptr;
  assign o_scm_wdata = i_push_data;

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN
  logic            r_almost_full;
  fifo_scm_flags_t w_flags;

  always_ff @(posedge i_clk) begin
    if (w_in_rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (32'(w_alloc_cnt_next) >= ALMOST_FULL_TH);
    end
  end

  assign w_flags = '{
    empty:       w_in_rst | (r_alloc_cnt == '0),
    full:        ~w_in_rst & (r_alloc_cnt == DepthCnt),
    almost_full: r_almost_full
  };

  assign o_empty       = w_flags.empty;
  assign o_full        = w_flags.full;
  assign o_almost_full = w_flags.almost_full;
  assign o_occupancy   = r_alloc_cnt;
`else
  assign o_empty = w_in_rst | (r_alloc_cnt == '0);
  assign o_full  = ~w_in_rst & (r_alloc_cnt == DepthCnt);
`endif

  a_th_range: assert property (@(posedge i_clk) ALMOST_FULL_TH <= Depth);

  a_no_push_full: assert property (@(posedge i_clk) disable iff (w_in_rst)
    !(w_push_fire && (r_alloc_cnt == DepthCnt)));

  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (w_in_rst)
    !(w_pop_fire && (r_alloc_cnt == '0)));

  a_cnt_range: assert property (@(posedge i_clk) disable iff (w_in_rst)
    r_alloc_cnt <= DepthCnt);

  a_pend_alloc: assert property (@(posedge i_clk) disable iff (w_in_rst)
    r_wr_pend |-> (r_alloc_cnt != '0));

endmodule

// File: tb/tb_hwpe_stream_fifo_scm_ctrl.sv
// Bench for the SCM FIFO controller: queue-based reference model plus directed checks.
module tb_hwpe_stream_fifo_scm_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF_TH = 2;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic          scm_re;
  logic [AW-1:0] scm_raddr;
  logic [DW-1:0] scm_rdata;
  logic          scm_we;
  logic [AW-1:0] scm_waddr;
  logic [DW-1:0] scm_wdata;
  logic          empty;
  logic          full;
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN
  logic          almost_full;
  logic [AW:0]   occupancy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hwpe_stream_fifo_scm_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .ALMOST_FULL_TH (AF_TH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (clear),
    .i_push_valid (push_valid),
    .o_push_ready (push_ready),
    .i_push_data  (push_data),
    .o_pop_valid  (pop_valid),
    .i_pop_ready  (pop_ready),
    .o_pop_data   (pop_data),
    .o_scm_re     (scm_re),
    .o_scm_raddr  (scm_raddr),
    .i_scm_rdata  (scm_rdata),
    .o_scm_we     (scm_we),
    .o_scm_waddr  (scm_waddr),
    .o_scm_wdata  (scm_wdata),
    .o_empty      (empty),
    .o_full       (full)
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN
    ,
    .o_almost_full (almost_full),
    .o_occupancy   (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage stand-in: write visible the cycle after the command, registered read address.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;
  always @(posedge clk) begin
    if (scm_we) mem[scm_waddr] <= scm_wdata;
    if (scm_re) raddr_q <= scm_raddr;
  end
  assign scm_rdata = mem[raddr_q];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, pointers as plain counters.
  logic [DW-1:0] q[$];
  int  wcnt = 0;
  int  rcnt = 0;
  bit  e_af = 1'b0;

  always @(negedge clk) begin
    bit e_pr, e_pv, e_pf, e_wf;
    if (rst || clear) begin
      check("m_rst_push_ready", 64'(push_ready), 64'd0);
      check("m_rst_pop_valid", 64'(pop_valid), 64'd0);
      check("m_rst_empty", 64'(empty), 64'd1);
      check("m_rst_full", 64'(full), 64'd0);
      check("m_rst_we", 64'(scm_we), 64'd0);
      check("m_rst_re", 64'(scm_re), 64'd1);
      check("m_rst_raddr", 64'(scm_raddr), 64'd0);
      q.delete();
      wcnt = 0;
      rcnt = 0;
      e_af = 1'b0;
    end else begin
      e_pr = (q.size() != DEPTH);
      e_pv = (q.size() > 0);
      e_pf = e_pv && pop_ready;
      e_wf = push_valid && e_pr;
      check("m_push_ready", 64'(push_ready), 64'(e_pr));
      check("m_pop_valid", 64'(pop_valid), 64'(e_pv));
      check("m_empty", 64'(empty), 64'(q.size() == 0));
      check("m_full", 64'(full), 64'(q.size() == DEPTH));
      check("m_re", 64'(scm_re), 64'd1);
      check("m_we", 64'(scm_we), 64'(e_wf));
      check("m_raddr", 64'(scm_raddr), 64'((rcnt + int'(e_pf)) % DEPTH));
      if (e_pv) check("m_pop_data", 64'(pop_data), 64'(q[0]));
      if (e_wf) begin
        check("m_waddr", 64'(scm_waddr), 64'(wcnt % DEPTH));
        check("m_wdata", 64'(scm_wdata), 64'(push_data));
      end
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_FLAGS_EN
      check("m_almost_full", 64'(almost_full), 64'(e_af));
      check("m_occupancy", 64'(occupancy), 64'(q.size()));
`endif
      if (e_pf) begin
        void'(q.pop_front());
        rcnt++;
      end
      if (e_wf) begin
        q.push_back(push_data);
        wcnt++;
      end
      e_af = (q.size() >= AF_TH);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    push_valid = 1'b1;
    push_data  = 32'hDEAD_BEEF;
    pop_ready  = 1'b1;
    @(negedge clk);
    check("rst_push_ready", 64'(push_ready), 64'd0);
    check("rst_scm_we", 64'(scm_we), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_raddr", 64'(scm_raddr), 64'd0);
    cyc();
    rst        = 1'b0;
    push_valid = 1'b0;

    // Idle after reset
    @(negedge clk);
    check("idle_empty", 64'(empty), 64'd1);
    check("idle_push_ready", 64'(push_ready), 64'd1);
    check("idle_pop_valid", 64'(pop_valid), 64'd0);
    check("idle_raddr", 64'(scm_raddr), 64'd0);
    check("idle_re", 64'(scm_re), 64'd1);

    // Single push into empty FIFO: no write-through, readable next cycle
    cyc();
    push_valid = 1'b1;
    push_data  = 32'hA5A5_0001;
    @(negedge clk);
    check("p1_pop_valid_c0", 64'(pop_valid), 64'd0);
    check("p1_waddr_c0", 64'(scm_waddr), 64'd0);
    cyc();
    push_valid = 1'b0;
    @(negedge clk);
    check("p1_pop_valid_c1", 64'(pop_valid), 64'd1);
    check("p1_pop_data_c1", 64'(pop_data), 64'hA5A5_0001);
    cyc();
    @(negedge clk);
    check("p1_empty_c2", 64'(empty), 64'd1);

    // Soft clear to restart pointers, then fill to full
    cyc();
    clear = 1'b1;
    cyc();
    clear     = 1'b0;
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_data  = 32'hB000_0000 + i;
      @(negedge clk);
      check("fill_waddr", 64'(scm_waddr), 64'(i));
      cyc();
    end
    push_data = 32'hB000_0004;
    @(negedge clk);
    check("full_flag", 64'(full), 64'd1);
    check("full_push_ready", 64'(push_ready), 64'd0);
    cyc();
    pop_ready = 1'b1;
    @(negedge clk);
    check("full_pop_no_bypass", 64'(push_ready), 64'd0);
    check("full_pop_data", 64'(pop_data), 64'hB000_0000);
    cyc();
    pop_ready = 1'b0;
    @(negedge clk);
    check("after_pop_push_ready", 64'(push_ready), 64'd1);
    check("wrap_waddr", 64'(scm_waddr), 64'd0);
    cyc();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    check("drain_empty", 64'(empty), 64'd1);

    // Continuous push and pop
    push_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_data = 32'hC000_0000 + i;
      cyc();
    end
    push_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(pop_valid), 64'd1);
    check("stream_last_data", 64'(pop_data), 64'hC000_000B);
    cyc();
    @(negedge clk);
    check("stream_empty", 64'(empty), 64'd1);

    // Backpressure with two entries
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_data  = 32'hD000_0000;
    cyc();
    push_data  = 32'hD000_0001;
    cyc();
    push_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pop_valid", 64'(pop_valid), 64'd1);
      check("bp_pop_data", 64'(pop_data), 64'hD000_0000);
      cyc();
    end

    // Clear with three entries
    push_valid = 1'b1;
    push_data  = 32'hD000_0002;
    cyc();
    clear     = 1'b1;
    push_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("clr_we", 64'(scm_we), 64'd0);
    check("clr_pop_valid", 64'(pop_valid), 64'd0);
    cyc();
    clear     = 1'b0;
    push_data = 32'h0000_1234;
    @(negedge clk);
    check("post_clr_empty", 64'(empty), 64'd1);
    check("post_clr_waddr", 64'(scm_waddr), 64'd0);
    check("post_clr_raddr", 64'(scm_raddr), 64'd0);
    cyc();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    @(negedge clk);
    check("post_clr_pop_valid", 64'(pop_valid), 64'd1);
    check("post_clr_pop_data", 64'(pop_data), 64'h0000_1234);
    cyc();
    @(negedge clk);
    check("final_empty", 64'(empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
